// File: rtl/axil_reg_pkg.sv
// Shared constants, FSM state type and mask helper for the AXI4-Lite register bridge.
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_RESP = 3'd4
    } state_t;

    // Mask of the address bits below a power-of-two byte count (span or word size).
    function automatic logic [63:0] low_mask(input int nbytes);
        return 64'(nbytes - 1);
    endfunction

endpackage

// File: rtl/axil_reg_bridge_hold.sv
// One-entry holding register for an AXI address or data channel.
// Ready is registered and means "empty"; the entry frees on the response handshake.
module axil_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_areset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             free,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // Capture on valid&&ready, release on free; ready tracks the empty state.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            full     <= 1'b0;
            in_ready <= 1'b0;
            data     <= '0;
        end else if (in_valid && in_ready) begin
            full     <= 1'b1;
            in_ready <= 1'b0;
            data     <= in_data;
        end else if (free) begin
            full     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            in_ready <= ~full;
        end
    end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave front-end turning one AXI access at a time into a
// request/acknowledge register access with window decode and timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a pending read or write, arbitrating fairly
// ST_WR_REQ  | reg_wr_req held, waiting for reg_ack or timeout
// ST_RD_REQ  | reg_rd_req held, waiting for reg_ack or timeout
// ST_WR_RESP | bvalid held until bready, then AW/W entries free
// ST_RD_RESP | rvalid held until rready, then AR entry frees
module axil_reg_bridge
    import axil_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    ADDR_SPAN      = 4096,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    reg_wr_req,
    output logic                    reg_rd_req,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic                    reg_ack,
    input  logic                    reg_err,
    input  logic [DATA_WIDTH-1:0]   reg_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_MASK  = ~ADDR_WIDTH'(low_mask(ADDR_SPAN));
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(low_mask(STRB_WIDTH));
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic                   last_wr;
    logic [CNT_WIDTH-1:0]   cnt;

    logic                   aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0]  aw_addr, ar_addr;
    logic [DATA_WIDTH+STRB_WIDTH-1:0] w_payload;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [STRB_WIDTH-1:0]  w_strb;

    logic                   wr_pend, rd_pend, grant_rd, grant_wr;
    logic                   wr_hit, rd_hit;
    logic [ADDR_WIDTH-1:0]  wr_off, rd_off;
    logic                   free_wr, free_rd;

    axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_hold_aw (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .in_data      (s_axi_awaddr),
        .in_valid     (s_axi_awvalid),
        .in_ready     (s_axi_awready),
        .free         (free_wr),
        .full         (aw_full),
        .data         (aw_addr)
    );

    axil_hold_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_hold_w (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .in_data      ({s_axi_wstrb, s_axi_wdata}),
        .in_valid     (s_axi_wvalid),
        .in_ready     (s_axi_wready),
        .free         (free_wr),
        .full         (w_full),
        .data         (w_payload)
    );

    axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_hold_ar (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .in_data      (s_axi_araddr),
        .in_valid     (s_axi_arvalid),
        .in_ready     (s_axi_arready),
        .free         (free_rd),
        .full         (ar_full),
        .data         (ar_addr)
    );

    assign w_data  = w_payload[DATA_WIDTH-1:0];
    assign w_strb  = w_payload[DATA_WIDTH +: STRB_WIDTH];

    // A write needs both address and data; a read only its address.
    assign wr_pend  = aw_full && w_full;
    assign rd_pend  = ar_full;
    assign grant_rd = rd_pend && (!wr_pend || last_wr);
    assign grant_wr = wr_pend && !grant_rd;

    assign wr_hit = (aw_addr & WIN_MASK) == BASE_ADDR;
    assign rd_hit = (ar_addr & WIN_MASK) == BASE_ADDR;
    assign wr_off = (aw_addr - BASE_ADDR) & WORD_MASK;
    assign rd_off = (ar_addr - BASE_ADDR) & WORD_MASK;

    // Response states always hold their valid high, so ready alone completes them.
    assign free_wr = (state == ST_WR_RESP) && s_axi_bready;
    assign free_rd = (state == ST_RD_RESP) && s_axi_rready;

    // Arbitration, register handshake with timeout, and AXI response generation.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state        <= ST_IDLE;
            last_wr      <= 1'b1;
            cnt          <= '0;
            reg_wr_req   <= 1'b0;
            reg_rd_req   <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_wstrb    <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (grant_rd) begin
                        last_wr <= 1'b0;
                        if (rd_hit) begin
                            state      <= ST_RD_REQ;
                            reg_rd_req <= 1'b1;
                            reg_addr   <= rd_off;
                        end else begin
                            state        <= ST_RD_RESP;
                            s_axi_rvalid <= 1'b1;
                            s_axi_rresp  <= RESP_DECERR;
                            s_axi_rdata  <= '0;
                        end
                    end else if (grant_wr) begin
                        last_wr <= 1'b1;
                        if (wr_hit) begin
                            state      <= ST_WR_REQ;
                            reg_wr_req <= 1'b1;
                            reg_addr   <= wr_off;
                            reg_wdata  <= w_data;
                            reg_wstrb  <= w_strb;
                        end else begin
                            state        <= ST_WR_RESP;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= RESP_DECERR;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (reg_ack) begin
                        state        <= ST_WR_RESP;
                        reg_wr_req   <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= reg_err ? RESP_SLVERR : RESP_OKAY;
                    end else if (cnt == CNT_LAST) begin
                        state        <= ST_WR_RESP;
                        reg_wr_req   <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= RESP_SLVERR;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                ST_RD_REQ: begin
                    if (reg_ack) begin
                        state        <= ST_RD_RESP;
                        reg_rd_req   <= 1'b0;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rresp  <= reg_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rdata  <= reg_err ? '0 : reg_rdata;
                    end else if (cnt == CNT_LAST) begin
                        state        <= ST_RD_RESP;
                        reg_rd_req   <= 1'b0;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rresp  <= RESP_SLVERR;
                        s_axi_rdata  <= '0;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                ST_WR_RESP: begin
                    if (s_axi_bready) begin
                        state        <= ST_IDLE;
                        s_axi_bvalid <= 1'b0;
                    end
                end
                ST_RD_RESP: begin
                    if (s_axi_rready) begin
                        state        <= ST_IDLE;
                        s_axi_rvalid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
